// File: rtl/antirrebote_botones.sv
// Up/down push-button conditioner: 2-flop sync, debounce, press pulse and
// hold-to-repeat per button, with cross-button conflict and enable gating.

module antirrebote_canal #(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_RATE  = 10000000,
  parameter int CNT_W        = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  input  logic blk_i,
  output logic estado_o,
  output logic pulso_o
);
  typedef enum logic [1:0] {SUELTO, ESPERA, REPITE} est_e;

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  logic             s1_q, s2_q;
  logic             estado_q, estado_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q;
  logic             pulso_q;
  est_e             st_q;

  always_comb begin
    db_cnt_d = db_cnt_q;
    estado_d = estado_q;
    if (s2_q == estado_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_cnt_d = '0;
      estado_d = ~estado_q;
    end else begin
      db_cnt_d = db_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      estado_q <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      s1_q     <= raw_i;
      s2_q     <= s1_q;
      estado_q <= estado_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // A release always wins over a due repeat, so no pulse is emitted on release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q      <= SUELTO;
      rep_cnt_q <= '0;
      pulso_q   <= 1'b0;
    end else begin
      pulso_q <= 1'b0;
      case (st_q)
        SUELTO: if (estado_q) begin
          st_q      <= ESPERA;
          rep_cnt_q <= DELAY_LAST;
          pulso_q   <= ~blk_i;
        end
        ESPERA, REPITE: begin
          if (!estado_q) begin
            st_q      <= SUELTO;
            rep_cnt_q <= '0;
          end else if (rep_cnt_q == '0) begin
            st_q      <= REPITE;
            rep_cnt_q <= RATE_LAST;
            pulso_q   <= ~blk_i;
          end else begin
            rep_cnt_q <= rep_cnt_q - CNT_W'(1);
          end
        end
        default: begin
          st_q      <= SUELTO;
          rep_cnt_q <= '0;
        end
      endcase
    end
  end

  assign estado_o = estado_q;
  assign pulso_o  = pulso_q;
endmodule

module antirrebote_botones #(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_RATE  = 10000000,
  parameter int CNT_W        = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ENi,
  input  logic [1:0] botones_raw,
  output logic [1:0] botones,
  output logic [1:0] estado
);
  logic [1:0] estado_w, pulso_w;
  logic       blk;

  // Both held, or output disabled: FSMs keep running but nothing is emitted.
  assign blk = (&estado_w) | ~ENi;

  for (genvar g = 0; g < 2; g++) begin : g_btn
    antirrebote_canal #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE),
      .CNT_W       (CNT_W)
    ) u_canal (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (botones_raw[g]),
      .blk_i   (blk),
      .estado_o(estado_w[g]),
      .pulso_o (pulso_w[g])
    );
  end

  assign botones = pulso_w;
  assign estado  = estado_w;
endmodule
